// File: rtl/wave_phase_gen.sv
// Phase-accumulator address generator for the square-wave lookup stage.
// Tuning word and duty select changes are staged and applied only at a period boundary.
module wave_phase_gen #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_tick,
  input  logic               i_load,
  input  logic [PHASE_W-1:0] i_ftw,
  input  logic [3:0]         i_sel,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [3:0]         o_sel,
  output logic               o_valid,
  output logic               o_wrap
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [PHASE_W-1:0] phase;
  logic               carry_q;
  logic [PHASE_W-1:0] act_ftw;
  logic [3:0]         act_sel;
  logic [PHASE_W-1:0] pend_ftw;
  logic [3:0]         pend_sel;
  logic               pend_v;

  logic               run_tick;
  logic               leave_run;
  logic [PHASE_W:0]   sum;
  logic               boundary;
  logic               take_new;
  logic               take_pend;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_en)  state_nxt = RUN;
      RUN:     if (!i_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A tick on the cycle i_en falls is dropped, so acceptance needs both RUN and i_en.
  assign run_tick  = (state == RUN) && i_en && i_tick;
  assign leave_run = (state == RUN) && !i_en;
  assign sum       = {1'b0, phase} + {1'b0, act_ftw};

  // A zero tuning word never carries, so every tick counts as a boundary to let updates land.
  assign boundary  = run_tick && (sum[PHASE_W] || (act_ftw == '0));
  assign take_new  = boundary && i_load;
  assign take_pend = boundary && !i_load && pend_v;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase   <= '0;
      carry_q <= 1'b1;
      o_addr  <= '0;
      o_sel   <= '0;
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
    end else begin
      o_valid <= run_tick;
      if (run_tick) begin
        o_addr  <= phase[PHASE_W-1 -: ADDR_W];
        o_sel   <= act_sel;
        o_wrap  <= carry_q;
        phase   <= sum[PHASE_W-1:0];
        carry_q <= sum[PHASE_W];
      end else if (leave_run) begin
        phase   <= '0;
        carry_q <= 1'b1;
      end
    end
  end

  // Configuration staging: direct in IDLE or on a boundary, otherwise parked as pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act_ftw  <= '0;
      act_sel  <= '0;
      pend_ftw <= '0;
      pend_sel <= '0;
      pend_v   <= 1'b0;
    end else if ((state == IDLE) && i_load) begin
      act_ftw <= i_ftw;
      act_sel <= i_sel;
      pend_v  <= 1'b0;
    end else if (state == RUN) begin
      if (take_new) begin
        act_ftw <= i_ftw;
        act_sel <= i_sel;
        pend_v  <= 1'b0;
      end else if (take_pend) begin
        act_ftw <= pend_ftw;
        act_sel <= pend_sel;
        pend_v  <= 1'b0;
      end else if (i_load) begin
        pend_ftw <= i_ftw;
        pend_sel <= i_sel;
        pend_v   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wave_phase_gen.sv
// Directed bench for wave_phase_gen: spec-level model checked every cycle plus literal sample checks.
module tb_wave_phase_gen;

  localparam int PHASE_W = 32;
  localparam int ADDR_W  = 10;
  localparam longint unsigned MODV  = 64'd1 << PHASE_W;
  localparam longint unsigned SCALE = 64'd1 << (PHASE_W - ADDR_W);

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               en = 1'b0;
  logic               tick = 1'b0;
  logic               load = 1'b0;
  logic [PHASE_W-1:0] ftw = '0;
  logic [3:0]         sel = '0;
  logic [ADDR_W-1:0]  o_addr;
  logic [3:0]         o_sel;
  logic               o_valid;
  logic               o_wrap;

  int checks = 0;
  int errors = 0;

  int q_addr[$];
  int q_sel[$];
  int q_wrap[$];

  wave_phase_gen #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_tick  (tick),
    .i_load  (load),
    .i_ftw   (ftw),
    .i_sel   (sel),
    .o_addr  (o_addr),
    .o_sel   (o_sel),
    .o_valid (o_valid),
    .o_wrap  (o_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase as an unbounded integer reduced modulo 2^PHASE_W.
  bit              m_run;
  longint unsigned m_phase;
  bit              m_start;
  longint unsigned m_aftw, m_pftw;
  int              m_asel, m_psel;
  bit              m_pv;
  int              e_addr, e_sel;
  bit              e_valid, e_wrap;
  bit              tk, wrapped, bnd;
  longint unsigned nxt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_phase = 0; m_start = 1;
      m_aftw = 0; m_asel = 0; m_pftw = 0; m_psel = 0; m_pv = 0;
      e_addr = 0; e_sel = 0; e_valid = 0; e_wrap = 0;
    end else begin
      tk = m_run && en && tick;
      bnd = 0;
      e_valid = tk;
      if (tk) begin
        e_addr  = int'(m_phase / SCALE);
        e_sel   = m_asel;
        e_wrap  = m_start;
        nxt     = m_phase + m_aftw;
        wrapped = (nxt >= MODV);
        m_phase = nxt % MODV;
        m_start = wrapped;
        bnd     = wrapped || (m_aftw == 0);
      end
      if (load && (!m_run || bnd)) begin
        m_aftw = longint'(ftw); m_asel = int'(sel); m_pv = 0;
      end else if (bnd && m_pv) begin
        m_aftw = m_pftw; m_asel = m_psel; m_pv = 0;
      end else if (load) begin
        m_pftw = longint'(ftw); m_psel = int'(sel); m_pv = 1;
      end
      if (m_run && !en) begin
        m_phase = 0; m_start = 1;
      end
      m_run = en;
    end
  end

  always @(negedge clk) begin
    check("valid", int'(o_valid), int'(e_valid));
    check("addr",  int'(o_addr),  e_addr);
    check("sel",   int'(o_sel),   e_sel);
    check("wrap",  int'(o_wrap),  int'(e_wrap));
    if (o_valid) begin
      q_addr.push_back(int'(o_addr));
      q_sel.push_back(int'(o_sel));
      q_wrap.push_back(int'(o_wrap));
    end
  end

  task automatic step(input bit e, input bit t, input bit l,
                      input logic [PHASE_W-1:0] f, input logic [3:0] s);
    en = e; tick = t; load = l; ftw = f; sel = s;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1, 1, 0, '0, '0);
  endtask

  task automatic clear_log();
    q_addr.delete(); q_sel.delete(); q_wrap.delete();
  endtask

  task automatic sample(input string name, input int idx, input int a, input int s, input int w);
    if (idx >= q_addr.size()) begin
      checks++; errors++;
      $display("FAIL %s: sample %0d missing, only %0d samples", name, idx, q_addr.size());
    end else begin
      check({name, ".addr"}, q_addr[idx], a);
      check({name, ".sel"},  q_sel[idx],  s);
      check({name, ".wrap"}, q_wrap[idx], w);
    end
  endtask

  task automatic start_run(input logic [PHASE_W-1:0] f, input logic [3:0] s);
    step(0, 0, 0, '0, '0);
    step(0, 0, 1, f, s);
    step(1, 0, 0, '0, '0);
    clear_log();
  endtask

  int nwrap;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", int'(o_valid), 0);
    check("rst.addr",  int'(o_addr),  0);
    check("rst.sel",   int'(o_sel),   0);
    check("rst.wrap",  int'(o_wrap),  0);
    rst_n = 1'b1;

    // Address ramp
    start_run(32'h0040_0000, 4'd5);
    ticks(1025);
    step(1, 0, 0, '0, '0);
    check("ramp.count", q_addr.size(), 1025);
    sample("ramp0", 0, 0, 5, 1);
    sample("ramp1", 1, 1, 5, 0);
    sample("ramp1023", 1023, 1023, 5, 0);
    sample("ramp1024", 1024, 0, 5, 1);
    nwrap = 0;
    foreach (q_wrap[i]) nwrap += q_wrap[i];
    check("ramp.wraps", nwrap, 2);

    // Half-scale step
    start_run(32'h8000_0000, 4'd5);
    ticks(4);
    step(1, 0, 0, '0, '0);
    sample("half0", 0, 0, 5, 1);
    sample("half1", 1, 512, 5, 0);
    sample("half2", 2, 0, 5, 1);
    sample("half3", 3, 512, 5, 0);

    // Mid-period update, second load overrides first
    start_run(32'h0040_0000, 4'd5);
    ticks(300);
    step(1, 1, 1, 32'h0080_0000, 4'd2);
    ticks(199);
    step(1, 1, 1, 32'h0080_0000, 4'd7);
    ticks(527);
    step(1, 0, 0, '0, '0);
    sample("mid300", 300, 300, 5, 0);
    sample("mid1023", 1023, 1023, 5, 0);
    sample("mid1024", 1024, 0, 7, 1);
    sample("mid1025", 1025, 2, 7, 0);
    sample("mid1027", 1027, 6, 7, 0);

    // Zero tuning word with a pending update
    start_run('0, 4'd9);
    step(1, 0, 1, 32'h0040_0000, 4'd3);
    ticks(3);
    step(1, 0, 0, '0, '0);
    sample("zero0", 0, 0, 9, 1);
    sample("zero1", 1, 0, 3, 0);
    sample("zero2", 2, 1, 3, 0);

    // Disable at address 700, tick on falling cycle and in IDLE ignored
    start_run(32'h0040_0000, 4'd5);
    ticks(701);
    step(0, 1, 0, '0, '0);
    repeat (3) step(0, 1, 0, '0, '0);
    check("dis.count", q_addr.size(), 701);
    sample("dis700", 700, 700, 5, 0);
    clear_log();
    step(1, 0, 0, '0, '0);
    ticks(2);
    step(1, 0, 0, '0, '0);
    sample("reen0", 0, 0, 5, 1);
    sample("reen1", 1, 1, 5, 0);

    // Coincident load and carry beats an older pending update
    start_run(32'h8000_0000, 4'd4);
    step(1, 0, 1, 32'h0010_0000, 4'd8);
    ticks(1);
    step(1, 1, 1, 32'h0040_0000, 4'd6);
    ticks(3);
    step(1, 0, 0, '0, '0);
    sample("coin0", 0, 0, 4, 1);
    sample("coin1", 1, 512, 4, 0);
    sample("coin2", 2, 0, 6, 1);
    sample("coin3", 3, 1, 6, 0);
    sample("coin4", 4, 2, 6, 0);
    check("coin.pend_v", int'(dut.pend_v), 0);

    // Asynchronous reset mid-run
    start_run(32'h0040_0000, 4'd5);
    ticks(4);
    check("pre.valid", int'(o_valid), 1);
    check("pre.addr", int'(o_addr), 3);
    #1 rst_n = 1'b0;
    #1;
    check("arst.valid", int'(o_valid), 0);
    check("arst.addr",  int'(o_addr),  0);
    check("arst.sel",   int'(o_sel),   0);
    check("arst.wrap",  int'(o_wrap),  0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_log();
    repeat (3) step(0, 1, 0, '0, '0);
    check("post.count", q_addr.size(), 0);
    step(1, 0, 0, '0, '0);
    ticks(2);
    step(1, 0, 0, '0, '0);
    sample("post0", 0, 0, 0, 1);
    sample("post1", 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
